stream_decryptor: RTL and testbench

STREAM_DECRYPTOR -- requirements
Module: stream_decryptor

---
 rtl/stream_decryptor_pkg.sv | 21 ++
 rtl/stream_decryptor_if.sv | 22 ++
 rtl/stream_decryptor.sv | 87 ++++++++
 tb/tb_stream_decryptor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_decryptor_pkg.sv
// Shared cipher definitions for the stream encryptor/decryptor pair.
// Holds the secret key bytes, the message FSM encoding and the key lookup helper.
package stream_decryptor_pkg;

    localparam int SECRET_LEN = 7;
    localparam logic [8*SECRET_LEN-1:0] SECRET = "SECRETK";

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cipher_state_t;

    // Byte 0 of the string literal sits in the most significant byte.
    function automatic logic [7:0] secret_byte(input int unsigned idx);
        int unsigned pos;
        pos = idx % SECRET_LEN;
        return SECRET[8*(SECRET_LEN-1-pos) +: 8];
    endfunction

endpackage

// File: rtl/stream_decryptor_if.sv
// Byte stream handshake bundle: cipher bytes in (s_*), plain bytes out (m_*).
// The slave modport is the decryptor's view; master is the traffic source/sink.
interface stream_decryptor_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/stream_decryptor.sv
// Stream decryptor: plain = cipher - SECRET[key_idx], key restarts at every message.
// Latency: 1 cycle through a single output register, full throughput.
// Backpressure: s_ready follows the output register; held low while the final byte waits.
module stream_decryptor
    import stream_decryptor_pkg::*;
#(
    parameter int MSG_LEN = 22,
    parameter int SEC_LEN = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_decryptor_if.slave  bus,
    output logic               len_err,
    output logic               msg_done
);

    localparam int BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(MSG_LEN - 1);
    localparam logic [KW-1:0] LAST_KEY  = KW'(SEC_LEN - 1);

    cipher_state_t state_q, state_d;
    logic [BW-1:0] byte_idx;
    logic [KW-1:0] key_idx;
    logic          out_vld;
    logic [7:0]    out_dat;
    logic          out_last;

    logic          s_ready_c;
    logic          in_fire;
    logic          out_fire;
    logic          at_last_byte;
    logic          is_final;

    always_comb begin
        at_last_byte = (byte_idx == LAST_BYTE);
        is_final     = bus.s_last || at_last_byte;
        s_ready_c    = rst_n && (state_q != ST_DONE) && (!out_vld || bus.m_ready);
        in_fire      = bus.s_valid && s_ready_c;
        out_fire     = out_vld && bus.m_ready;
        msg_done     = rst_n && out_fire && out_last;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_fire) state_d = is_final ? ST_DONE : ST_RUN;
            ST_RUN:  if (in_fire && is_final) state_d = ST_DONE;
            ST_DONE: if (out_fire && out_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            byte_idx <= '0;
            key_idx  <= '0;
            out_vld  <= 1'b0;
            out_dat  <= 8'h00;
            out_last <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                out_vld  <= 1'b1;
                out_dat  <= bus.s_data - secret_byte(32'(key_idx));
                out_last <= is_final;
                // Indices are zeroed on the final byte so IDLE is always entered clean.
                if (is_final) begin
                    byte_idx <= '0;
                    key_idx  <= '0;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                    key_idx  <= (key_idx == LAST_KEY) ? '0 : key_idx + 1'b1;
                end
                if (bus.s_last != at_last_byte) len_err <= 1'b1;
            end else if (out_fire) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = out_vld;
    assign bus.m_data  = out_dat;
    assign bus.m_last  = out_last;

endmodule

// File: tb/tb_stream_decryptor.sv
// Randomized bench for stream_decryptor: plaintext is encrypted here with the
// encryptor rule, and the decrypted stream must reproduce it byte-exact.
module tb_stream_decryptor;

    localparam int MSG_LEN = 22;
    localparam int SEC_LEN = 7;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic len_err;
    logic msg_done;

    always #5 clk = ~clk;

    stream_decryptor_if bus();

    stream_decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .len_err  (len_err),
        .msg_done (msg_done)
    );

    string      key_str = "SECRETK";
    exp_t       exp_q[$];
    logic [7:0] msg_plain[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         ready_mode = 0;
    int         stall_cnt = 0;
    int         done_seen = 0;
    int         done_exp = 0;
    logic       exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Sink: 0 = always ready, 1 = toggling with random 3-cycle stalls, 2 = hold off.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: begin
                    if (stall_cnt > 0) begin
                        bus.m_ready = 1'b0;
                        stall_cnt--;
                    end else if ($urandom_range(0, 7) == 0) begin
                        bus.m_ready = 1'b0;
                        stall_cnt = 2;
                    end else begin
                        bus.m_ready = !bus.m_ready;
                    end
                end
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor / scoreboard.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_dat;
        logic       prev_last;
        exp_t       e;
        prev_stall = 1'b0;
        prev_dat   = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (msg_done) done_seen++;
                if (prev_stall) begin
                    check("hold_vld", 32'(bus.m_valid), 32'd1);
                    check("hold_dat", 32'(bus.m_data), 32'(prev_dat));
                    check("hold_last", 32'(bus.m_last), 32'(prev_last));
                end
                if (bus.m_valid && !bus.m_ready)
                    check("s_ready_stall", 32'(bus.s_ready), 32'd0);
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 32'(bus.m_data), 32'(e.dat));
                        check("m_last", 32'(bus.m_last), 32'(e.last));
                        check("msg_done", 32'(msg_done), 32'(e.last));
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_dat   = bus.m_data;
                prev_last  = bus.m_last;
            end
        end
    end

    task automatic send_byte(input logic [7:0] cdat, input logic clast,
                             input logic [7:0] pexp, input logic elast, input bit hold_after);
        int waited;
        bit ok;
        bus.s_valid = 1'b1;
        bus.s_data  = cdat;
        bus.s_last  = clast;
        waited = 0;
        ok = 0;
        while (!ok && waited < 300) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1;
                exp_q.push_back('{dat: pexp, last: elast});
                if (hold_after) ready_mode = 2;
            end else begin
                waited++;
            end
        end
        if (!ok) check("send_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'b0;
    endtask

    // Encrypts msg_plain with the sender's rule and streams up to nsend bytes.
    task automatic send_msg(input int nsend, input int last_at, input bit hold_last_sent);
        int term;
        int n;
        logic [7:0] c;
        term = (last_at >= 0 && last_at < MSG_LEN - 1) ? last_at : MSG_LEN - 1;
        n = (nsend < term + 1) ? nsend : term + 1;
        for (int i = 0; i < n; i++) begin
            c = msg_plain[i] + 8'(key_str[i % SEC_LEN]);
            send_byte(c, i == last_at, msg_plain[i], i == term, hold_last_sent && (i == n - 1));
            if (ready_mode == 1 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        if (n == term + 1) begin
            done_exp++;
            if (last_at != MSG_LEN - 1) exp_err = 1'b1;
        end
    endtask

    task automatic fill_random(input int n);
        msg_plain.delete();
        for (int i = 0; i < n; i++) msg_plain.push_back(8'($urandom));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        string hello;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_msg_done", 32'(msg_done), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Known plaintext, sink always ready.
        hello = "HELLOTHISISATESTMESSAG";
        msg_plain.delete();
        for (int i = 0; i < hello.len(); i++) msg_plain.push_back(8'(hello[i]));
        ready_mode = 0;
        send_msg(MSG_LEN, MSG_LEN - 1, 0);
        drain();
        check("hello_len_err", 32'(len_err), 32'd0);
        check("hello_done_cnt", 32'(done_seen), 32'(done_exp));

        // First byte wraps below zero: cipher 10 at key 0 decodes to BD.
        fill_random(MSG_LEN);
        msg_plain[0] = 8'hBD;
        ready_mode = 1;
        send_msg(MSG_LEN, MSG_LEN - 1, 0);
        drain();

        for (int k = 0; k < 4; k++) begin
            fill_random(MSG_LEN);
            send_msg(MSG_LEN, MSG_LEN - 1, 0);
            drain();
        end
        check("random_len_err", 32'(len_err), 32'(exp_err));

        // Early s_last terminates the message and latches the error.
        ready_mode = 0;
        fill_random(MSG_LEN);
        send_msg(MSG_LEN, 4, 0);
        drain();
        check("short_len_err", 32'(len_err), 32'(exp_err));
        ready_mode = 1;
        fill_random(MSG_LEN);
        send_msg(MSG_LEN, MSG_LEN - 1, 0);
        drain();
        check("sticky_len_err", 32'(len_err), 32'(exp_err));

        // Reset while byte 10 is held in the output register.
        ready_mode = 0;
        fill_random(MSG_LEN);
        send_msg(11, MSG_LEN - 1, 1);
        @(negedge clk);
        check("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_m_data", 32'(bus.m_data), 32'd0);
        check("mid_rst_m_last", 32'(bus.m_last), 32'd0);
        check("mid_rst_len_err", 32'(len_err), 32'd0);
        check("mid_rst_msg_done", 32'(msg_done), 32'd0);
        exp_q.delete();
        exp_err = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        ready_mode = 1;
        fill_random(MSG_LEN);
        send_msg(MSG_LEN, MSG_LEN - 1, 0);
        drain();
        check("final_len_err", 32'(len_err), 32'(exp_err));
        check("msg_done_count", 32'(done_seen), 32'(done_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
